// File: rtl/bullet_scheduler.sv
// Shared projectile slot pool: arbitrates two players' shoot requests into free slots
// with per-player cooldown, and steps every slot's position once per frame tick.
module bullet_scheduler #(
    parameter int NUM_SLOTS       = 4,
    parameter int COOLDOWN_FRAMES = 8,
    parameter int BULLET_SPEED    = 4,
    parameter int SCREEN_W        = 640,
    parameter int POS_BITS        = 10
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          frame_tick_i,
    input  logic                          player_1_shoot_i,
    input  logic                          player_2_shoot_i,
    input  logic [POS_BITS-1:0]           player_1_x_i,
    input  logic [POS_BITS-1:0]           player_1_y_i,
    input  logic [POS_BITS-1:0]           player_2_x_i,
    input  logic [POS_BITS-1:0]           player_2_y_i,
    output logic                          busy_o,
    output logic                          grant_1_o,
    output logic                          grant_2_o,
    output logic                          drop_o,
    output logic [NUM_SLOTS-1:0]          slot_valid_o,
    output logic [NUM_SLOTS-1:0]          slot_owner_o,
    output logic [NUM_SLOTS*POS_BITS-1:0] slot_x_o,
    output logic [NUM_SLOTS*POS_BITS-1:0] slot_y_o
);
    localparam int IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam logic [IDX_W-1:0]    LAST_IDX  = IDX_W'(NUM_SLOTS - 1);
    localparam logic [POS_BITS:0]   SPEED_W   = (POS_BITS+1)'(BULLET_SPEED);
    localparam logic [POS_BITS-1:0] SPEED_N   = POS_BITS'(BULLET_SPEED);
    localparam logic [POS_BITS:0]   SCREEN_LIM = (POS_BITS+1)'(SCREEN_W);
    localparam logic [7:0]          COOLDOWN  = 8'(COOLDOWN_FRAMES);

    typedef enum logic {IDLE, UPDATE} state_t;

    state_t              state, state_next;
    logic [IDX_W-1:0]    idx, idx_next;
    logic [1:0]          shoot_q, pending, rise;
    logic [7:0]          cooldown [2];
    logic                prio;  // 0 = player 1 wins a tie
    logic [NUM_SLOTS-1:0] valid, owner;
    logic [POS_BITS-1:0] xs [NUM_SLOTS];
    logic [POS_BITS-1:0] ys [NUM_SLOTS];

    logic                arb, winner, have_free, kill;
    logic [IDX_W-1:0]    free_idx;
    logic [POS_BITS-1:0] spawn_x, spawn_y, cur_x, new_x;
    logic [POS_BITS:0]   sum;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
        end
    end

    always_comb begin
        state_next = state;
        idx_next   = idx;
        case (state)
            IDLE: if (frame_tick_i) begin
                state_next = UPDATE;
                idx_next   = '0;
            end
            UPDATE: begin
                if (idx == LAST_IDX) begin
                    state_next = IDLE;
                    idx_next   = '0;
                end else begin
                    idx_next = idx + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        rise      = {player_2_shoot_i, player_1_shoot_i} & ~shoot_q;
        arb       = (state == IDLE) && !frame_tick_i && (pending != 2'b00);
        winner    = (pending == 2'b11) ? prio : pending[1];
        spawn_x   = winner ? player_2_x_i : player_1_x_i;
        spawn_y   = winner ? player_2_y_i : player_1_y_i;
        have_free = 1'b0;
        free_idx  = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!valid[i]) begin
                have_free = 1'b1;
                free_idx  = IDX_W'(i);
            end
        end
        // Movement is evaluated one bit wider so the right-edge test cannot wrap.
        cur_x = xs[idx];
        sum   = {1'b0, cur_x} + SPEED_W;
        kill  = owner[idx] ? ({1'b0, cur_x} < SPEED_W) : (sum >= SCREEN_LIM);
        new_x = owner[idx] ? (cur_x - SPEED_N) : sum[POS_BITS-1:0];
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            shoot_q   <= '0;
            pending   <= '0;
            cooldown  <= '{default: '0};
            prio      <= 1'b0;
            valid     <= '0;
            owner     <= '0;
            xs        <= '{default: '0};
            ys        <= '{default: '0};
            grant_1_o <= 1'b0;
            grant_2_o <= 1'b0;
            drop_o    <= 1'b0;
        end else begin
            shoot_q   <= {player_2_shoot_i, player_1_shoot_i};
            grant_1_o <= 1'b0;
            grant_2_o <= 1'b0;
            drop_o    <= 1'b0;
            for (int p = 0; p < 2; p++) begin
                if (state == IDLE && frame_tick_i && cooldown[p] != 8'd0)
                    cooldown[p] <= cooldown[p] - 8'd1;
                if (rise[p] && cooldown[p] == 8'd0)
                    pending[p] <= 1'b1;
            end
            if (arb) begin
                pending[winner] <= 1'b0;
                if (have_free) begin
                    valid[free_idx]  <= 1'b1;
                    owner[free_idx]  <= winner;
                    xs[free_idx]     <= spawn_x;
                    ys[free_idx]     <= spawn_y;
                    cooldown[winner] <= COOLDOWN;
                    prio             <= ~winner;
                    if (winner) grant_2_o <= 1'b1;
                    else        grant_1_o <= 1'b1;
                end else begin
                    drop_o <= 1'b1;
                end
            end
            if (state == UPDATE && valid[idx]) begin
                if (kill) valid[idx] <= 1'b0;
                else      xs[idx]    <= new_x;
            end
        end
    end

    always_comb begin
        busy_o       = (state == UPDATE);
        slot_valid_o = valid;
        slot_owner_o = owner;
        slot_x_o     = '0;
        slot_y_o     = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            slot_x_o[i*POS_BITS +: POS_BITS] = xs[i];
            slot_y_o[i*POS_BITS +: POS_BITS] = ys[i];
        end
    end
endmodule

// File: tb/tb_bullet_scheduler.sv
// Directed bench for bullet_scheduler: expected grant/drop events are queued by the
// stimulus and consumed by a negedge monitor; slot state is also checked directly.
module tb_bullet_scheduler;
    localparam int NS = 4;
    localparam int PB = 10;
    localparam int W  = 25;  // {drop, g2, g1, slot[1:0], x[9:0], y[9:0]}

    logic          clk = 1'b0;
    logic          reset_i = 1'b1;
    logic          frame_tick_i = 1'b0;
    logic          p1_shoot = 1'b0, p2_shoot = 1'b0;
    logic [PB-1:0] p1_x = '0, p1_y = '0, p2_x = '0, p2_y = '0;
    logic          busy_o, grant_1_o, grant_2_o, drop_o;
    logic [NS-1:0] slot_valid_o, slot_owner_o;
    logic [NS*PB-1:0] slot_x_o, slot_y_o;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] item;
    int           n_checks = 0;
    int           n_pass   = 0;
    int           busy_cnt;
    int           s;

    bullet_scheduler #(
        .NUM_SLOTS(NS), .COOLDOWN_FRAMES(8), .BULLET_SPEED(4), .SCREEN_W(640), .POS_BITS(PB)
    ) dut (
        .clk_i(clk), .reset_i(reset_i), .frame_tick_i(frame_tick_i),
        .player_1_shoot_i(p1_shoot), .player_2_shoot_i(p2_shoot),
        .player_1_x_i(p1_x), .player_1_y_i(p1_y),
        .player_2_x_i(p2_x), .player_2_y_i(p2_y),
        .busy_o(busy_o), .grant_1_o(grant_1_o), .grant_2_o(grant_2_o), .drop_o(drop_o),
        .slot_valid_o(slot_valid_o), .slot_owner_o(slot_owner_o),
        .slot_x_o(slot_x_o), .slot_y_o(slot_y_o)
    );

    // clock / watchdog
    always #5 clk = ~clk;
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, pending events %0d", exp_q.size());
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_ev(input logic [2:0] kind, input int slot, input int x, input int y);
        exp_q.push_back({kind, 2'(slot), 10'(x), 10'(y)});
    endtask

    task automatic wait_drain(input string name, input int max_cycles);
        for (int i = 0; i < max_cycles && exp_q.size() != 0; i++) step(1);
        step(2);
        check(name, exp_q.size(), 0);
    endtask

    task automatic do_reset();
        p1_shoot = 1'b0;
        p2_shoot = 1'b0;
        frame_tick_i = 1'b0;
        reset_i = 1'b1;
        step(2);
        reset_i = 1'b0;
        step(1);
    endtask

    task automatic frame();
        frame_tick_i = 1'b1;
        step(1);
        frame_tick_i = 1'b0;
        step(NS + 2);
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) frame();
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (!reset_i && (grant_1_o || grant_2_o || drop_o)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_event", {29'b0, drop_o, grant_2_o, grant_1_o}, 0);
            end else begin
                item = exp_q.pop_front();
                check("event_kind", {29'b0, drop_o, grant_2_o, grant_1_o}, {29'b0, item[24:22]});
                if (!item[24]) begin
                    s = int'(item[21:20]);
                    check("grant_slot_valid", {31'b0, slot_valid_o[s]}, 1);
                    check("grant_slot_owner", {31'b0, slot_owner_o[s]}, {31'b0, item[23]});
                    check("grant_slot_x", {22'b0, slot_x_o[s*PB +: PB]}, {22'b0, item[19:10]});
                    check("grant_slot_y", {22'b0, slot_y_o[s*PB +: PB]}, {22'b0, item[9:0]});
                end
            end
        end
    end

    initial begin
        step(2);
        check("reset_busy", {31'b0, busy_o}, 0);
        check("reset_valid", {28'b0, slot_valid_o}, 0);
        check("reset_pulses", {29'b0, drop_o, grant_2_o, grant_1_o}, 0);
        reset_i = 1'b0;
        step(1);

        // single press, then hold
        p1_x = 10'd100; p1_y = 10'd50;
        p1_shoot = 1'b1;
        expect_ev(3'b001, 0, 100, 50);
        step(1);
        check("no_grant_same_edge", {31'b0, grant_1_o}, 0);
        step(1);
        @(negedge clk);
        check("grant_latency", {31'b0, grant_1_o}, 1);
        step(20);
        check("hold_drain", exp_q.size(), 0);
        p1_shoot = 1'b0;
        step(1);

        // asynchronous reset in the middle of UPDATE (idx = 2)
        frame_tick_i = 1'b1;
        step(1);
        frame_tick_i = 1'b0;
        step(2);
        check("busy_before_reset", {31'b0, busy_o}, 1);
        #2 reset_i = 1'b1;
        #1;
        check("async_reset_busy", {31'b0, busy_o}, 0);
        check("async_reset_valid", {28'b0, slot_valid_o}, 0);
        step(1);
        reset_i = 1'b0;
        step(1);

        // simultaneous presses, then a repeat contest after cooldowns expire
        p1_x = 10'd10;  p1_y = 10'd20;
        p2_x = 10'd600; p2_y = 10'd30;
        expect_ev(3'b001, 0, 10, 20);
        expect_ev(3'b010, 1, 600, 30);
        p1_shoot = 1'b1; p2_shoot = 1'b1;
        wait_drain("contest1_drain", 10);
        p1_shoot = 1'b0; p2_shoot = 1'b0;
        step(1);
        frames(8);
        check("p1_moved_x", {22'b0, slot_x_o[0*PB +: PB]}, 42);
        check("p2_moved_x", {22'b0, slot_x_o[1*PB +: PB]}, 568);
        check("y_unchanged", {22'b0, slot_y_o[1*PB +: PB]}, 30);
        expect_ev(3'b001, 2, 10, 20);
        expect_ev(3'b010, 3, 600, 30);
        p1_shoot = 1'b1; p2_shoot = 1'b1;
        wait_drain("contest2_drain", 10);
        p1_shoot = 1'b0; p2_shoot = 1'b0;
        step(1);

        // pool full: P2 request is dropped and leaves no cooldown behind
        frames(8);
        check("pool_full", {28'b0, slot_valid_o}, 4'hF);
        expect_ev(3'b100, 0, 0, 0);
        p2_shoot = 1'b1;
        wait_drain("drop1_drain", 10);
        p2_shoot = 1'b0;
        step(1);
        expect_ev(3'b100, 0, 0, 0);
        p2_shoot = 1'b1;
        wait_drain("drop2_drain", 10);
        p2_shoot = 1'b0;
        step(3);

        // frame update: right mover advances, left mover at x=3 expires
        do_reset();
        p1_x = 10'd500; p1_y = 10'd7;
        expect_ev(3'b001, 0, 500, 7);
        p1_shoot = 1'b1;
        wait_drain("spawn500_drain", 10);
        p1_shoot = 1'b0;
        p2_x = 10'd3; p2_y = 10'd9;
        expect_ev(3'b010, 1, 3, 9);
        p2_shoot = 1'b1;
        wait_drain("spawn3_drain", 10);
        p2_shoot = 1'b0;
        step(1);
        frame_tick_i = 1'b1;
        @(posedge clk);
        #1 frame_tick_i = 1'b0;
        busy_cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (busy_o) busy_cnt++;
        end
        step(1);
        check("busy_cycles", busy_cnt, NS);
        check("slot0_x_504", {22'b0, slot_x_o[0*PB +: PB]}, 504);
        check("update_valid", {28'b0, slot_valid_o}, 4'b0001);

        // right edge: x=636 + 4 reaches the screen width
        do_reset();
        p1_x = 10'd636; p1_y = 10'd1;
        expect_ev(3'b001, 0, 636, 1);
        p1_shoot = 1'b1;
        wait_drain("spawn636_drain", 10);
        p1_shoot = 1'b0;
        step(1);
        frame();
        check("right_edge_expire", {28'b0, slot_valid_o}, 0);

        // cooldown: press after 3 frames is ignored, after 8 frames is granted
        do_reset();
        p1_x = 10'd100; p1_y = 10'd50;
        expect_ev(3'b001, 0, 100, 50);
        p1_shoot = 1'b1;
        wait_drain("cd_first_drain", 10);
        p1_shoot = 1'b0;
        step(1);
        frames(3);
        p1_shoot = 1'b1;
        step(6);
        check("cd_ignored_valid", {28'b0, slot_valid_o}, 4'b0001);
        p1_shoot = 1'b0;
        step(1);
        frames(5);
        expect_ev(3'b001, 1, 100, 50);
        p1_shoot = 1'b1;
        wait_drain("cd_expired_drain", 10);
        p1_shoot = 1'b0;
        step(3);

        check("final_queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/bullet_scheduler.md
Name: bullet_scheduler

Overview:
- Owns a shared pool of NUM_SLOTS projectile slots used by both players.
- Arbitrates player shoot requests into free slots and applies a per-player cooldown.
- On each frame tick, sequences the per-frame position update across all slots.
- Sits between the player input logic and the renderer inside game_top; the renderer reads the slot state outputs directly.

Parameters:
NUM_SLOTS, 4, number of shared projectile slots (>=2)
COOLDOWN_FRAMES, 8, frames a player is blocked after a grant (>=1, fits in 8 bits)
BULLET_SPEED, 4, pixels moved per frame
SCREEN_W, 640, visible width; legal x range is 0..SCREEN_W-1
POS_BITS, 10, position width

Ports:
clk_i  in  1  clock
reset_i  in  1  asynchronous, active-high reset
frame_tick_i  in  1  one-cycle pulse at start of vblank
player_1_shoot_i  in  1  level shoot button, player 1
player_2_shoot_i  in  1  level shoot button, player 2
player_1_x_i / player_1_y_i  in  POS_BITS each  player 1 spawn position
player_2_x_i / player_2_y_i  in  POS_BITS each  player 2 spawn position
busy_o  out  1  high while in UPDATE
grant_1_o / grant_2_o  out  1  one-cycle pulse, slot allocated to that player
drop_o  out  1  one-cycle pulse, request discarded because no slot was free
slot_valid_o  out  NUM_SLOTS  per-slot active flag
slot_owner_o  out  NUM_SLOTS  0 = player 1, 1 = player 2
slot_x_o  out  NUM_SLOTS*POS_BITS  packed x; slot i at [i*POS_BITS +: POS_BITS]
slot_y_o  out  NUM_SLOTS*POS_BITS  packed y, same packing as slot_x_o

Behaviour:
- Reset, asynchronous: all outputs 0, slots invalid, pending flags 0, cooldowns 0, shoot history 0, priority = player 1, state IDLE, idx 0.
- Edge detect: the previous shoot level is registered per player. A rising edge sets pending[p] only if cooldown[p]==0; otherwise the edge is silently ignored.
- Holding the button never re-fires; it must be released and pressed again.
- FSM states: IDLE, UPDATE.
- IDLE, frame_tick_i=1:
  - go to UPDATE, idx=0;
  - every nonzero cooldown decrements by 1;
  - no grant is issued that cycle.
- IDLE, no tick: at most one grant per cycle.
  - Eligible players are those with pending=1.
  - If both are eligible, the one holding priority wins; after any grant, priority moves to the other player.
  - The winner takes the lowest-index invalid slot: valid=1, owner=p, x/y = player x/y.
  - Also: cooldown[p] = COOLDOWN_FRAMES, pending[p] cleared, grant_p_o pulses.
  - If no slot is free: the winner's pending is cleared, drop_o pulses, and priority is unchanged. The loser stays pending and resolves next cycle.
- Latency: rising edge sampled at edge k sets pending at k. Grant and slot_valid are visible after edge k+1, assuming IDLE, no tick, and priority held or uncontested.
- UPDATE: processes one slot per cycle, slot idx. Valid slots only; arithmetic is in POS_BITS+1 bits.
  - Owner 0: if x+BULLET_SPEED >= SCREEN_W then valid=0, else x += BULLET_SPEED.
  - Owner 1: if x < BULLET_SPEED then valid=0, else x -= BULLET_SPEED.
  - y is never modified.
  - Invalid slots are untouched.
  - After idx==NUM_SLOTS-1, return to IDLE. UPDATE always lasts exactly NUM_SLOTS cycles.
- During UPDATE:
  - frame_tick_i is ignored;
  - shoot edges still set pending, subject to the cooldown check;
  - no grants are issued; pending requests are serviced in IDLE.
- busy_o = (state==UPDATE), registered.
- A slot freed in UPDATE is reusable from the first IDLE cycle after UPDATE.
- Unused position bits above SCREEN_W are never produced.

Test Plan:
- Reset mid-UPDATE (idx=2) -> all slots invalid, busy_o=0, priority p1 within the same cycle, asynchronously.
- P1 presses at x=100,y=50, IDLE -> one cycle later: grant_1_o pulse, slot0 valid, owner 0, x=100, y=50. Holding the button 20 cycles gives no further grants.
- Both press in the same cycle from reset -> P1 gets slot0 first, P2 gets slot1 on the next cycle. A repeat contest after both cooldowns expire favors P1 again, since priority toggled twice.
- P1 slot at x=636, P2 slot at x=3, frame tick -> busy_o high 4 cycles; both slots invalid after UPDATE. A P1 slot at x=500 becomes 504.
- 4 slots full, P2 presses -> drop_o pulse, no grant, pending cleared, cooldown stays 0.
- P1 granted, presses again after 3 frame ticks -> ignored. Presses again after 8 ticks -> granted.
